// File: rtl/delay_pipeline_pkg.sv
// Shared constants and helpers for the delay_pipeline register chain.
package delay_pipeline_pkg;

  localparam int MODE_FIXED    = 0;
  localparam int MODE_COLLAPSE = 1;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_pipeline_if.sv
// Handshake, data and observation signals of one delay_pipeline instance.
interface delay_pipeline_if #(
  parameter int n     = 1,
  parameter int DEPTH = 4
);
  import delay_pipeline_pkg::*;

  localparam int CW = clog2(DEPTH + 1);

  logic                 clear;
  logic                 enable;
  logic [n-1:0]         in;
  logic                 inValid;
  logic                 inReady;
  logic [n-1:0]         out;
  logic                 outValid;
  logic [n*DEPTH-1:0]   taps;
  logic [DEPTH-1:0]     tapValid;
  logic [CW-1:0]        count;

  modport master (
    output clear, enable, in, inValid,
    input  inReady, out, outValid, taps, tapValid, count
  );

  modport slave (
    input  clear, enable, in, inValid,
    output inReady, out, outValid, taps, tapValid, count
  );

endinterface

// File: rtl/delay_pipeline_pipe_stage.sv
// One pipeline stage: data and valid registers; invalid stages always hold zero data.
module pipe_stage #(
  parameter int n = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [n-1:0] prev_d,
  input  logic         prev_v,
  output logic [n-1:0] d,
  output logic         v,
  output logic         v_next
);

  logic [n-1:0] d_d, d_q;
  logic         v_d, v_q;

  always_comb begin
    d_d = d_q;
    v_d = v_q;
    if (clear) begin
      d_d = '0;
      v_d = 1'b0;
    end else if (load) begin
      v_d = prev_v;
      d_d = prev_v ? prev_d : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q <= '0;
      v_q <= 1'b0;
    end else begin
      d_q <= d_d;
      v_q <= v_d;
    end
  end

  assign d      = d_q;
  assign v      = v_q;
  assign v_next = v_d;

endmodule

// File: rtl/delay_pipeline.sv
// N-stage register pipeline with per-stage valids, stall, flush and optional bubble collapsing.
module delay_pipeline
  import delay_pipeline_pkg::*;
#(
  parameter int n        = 1,
  parameter int DEPTH    = 4,
  parameter int COLLAPSE = MODE_FIXED
) (
  input  logic           clk,
  input  logic           reset,
  delay_pipeline_if.slave bus
);

  localparam int CW = clog2(DEPTH + 1);

  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_next;
  logic [DEPTH-1:0] prev_v;
  logic [n-1:0]     d      [DEPTH];
  logic [n-1:0]     prev_d [DEPTH];
  logic [CW-1:0]    count_d, count_q;

  // Collapsing ripple adv[i] = adv[i+1] | ~v[i] unrolled: a stage moves unless it and
  // every stage downstream of it is full while the consumer is stalled.
  always_comb begin : adv_chain
    logic all_full;
    all_full = 1'b1;
    adv      = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (COLLAPSE == MODE_COLLAPSE) begin
        all_full = all_full & v[i];
        adv[i]   = bus.enable | ~all_full;
      end else begin
        adv[i] = bus.enable;
      end
    end
  end

  always_comb begin
    prev_d[0] = bus.in;
    prev_v[0] = bus.inValid;
    for (int i = 1; i < DEPTH; i++) begin
      prev_d[i] = d[i-1];
      prev_v[i] = v[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_stage #(.n(n)) u_stage (
      .clk    (clk),
      .reset  (reset),
      .clear  (bus.clear),
      .load   (adv[i]),
      .prev_d (prev_d[i]),
      .prev_v (prev_v[i]),
      .d      (d[i]),
      .v      (v[i]),
      .v_next (v_next[i])
    );
    assign bus.taps[i*n +: n] = d[i];
  end

  // Occupancy is registered from the next-state valids so it tracks v cycle for cycle.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(v_next[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.inReady  = adv[0] & ~bus.clear & ~reset;
  assign bus.out      = d[DEPTH-1];
  assign bus.outValid = v[DEPTH-1];
  assign bus.tapValid = v;
  assign bus.count    = count_q;

endmodule

// File: doc/delay_pipeline.md
# delay_pipeline

Parametrised multi-stage register pipeline with per-stage valid bits, stall control and an optional bubble-collapsing mode. It replaces hand-chained single enabled flip-flops wherever game datapaths need a fixed N-cycle delay, such as aligning sprite and pixel data with VGA timing, or a short elastic buffer between a producer and a stalling consumer. It exposes every stage as a tap and reports its current occupancy.

## Interface
- n, 1, data width per stage (>=1)
- DEPTH, 4, number of stages (>=1)
- COLLAPSE, 0, 0 = fixed-delay lockstep mode; 1 = bubble-collapsing elastic mode

- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  asynchronous, active-high; clears all stages immediately
- clear  input  1  synchronous flush; takes priority over all other inputs
- enable  input  1  advance / downstream-accept
- in  input  n  data into stage 0
- inValid  input  1  in carries a valid item
- inReady  output  1  stage 0 loads on this clock edge
- out  output  n  data of stage DEPTH-1
- outValid  output  1  valid bit of stage DEPTH-1
- taps  output  n*DEPTH  all stage data; stage i at bits [i*n +: n]
- tapValid  output  DEPTH  valid bit of each stage
- count  output  $clog2(DEPTH+1)  number of valid stages

## Operation
- Per stage i: data register d[i] and valid register v[i].
- Advance signal adv[i]: stage i loads from its predecessor (stage 0 loads from in/inValid).
  - COLLAPSE=0: adv[i] = enable for every i.
  - COLLAPSE=1: adv[DEPTH-1] = enable | ~v[DEPTH-1]; adv[i] = adv[i+1] | ~v[i].
- On load: v[i] <= predecessor valid. d[i] <= predecessor data if predecessor valid, else 0. Invalid stages always hold zero data.
- No load: stage holds.
- inReady = adv[0] (combinational). COLLAPSE=0: inReady = enable, and inValid is sampled regardless of handshake.
- Output transfer occurs when outValid & enable. In COLLAPSE=1, an item is never dropped or duplicated.
- count = popcount(v), updated in the same cycle as v.
- clear = 1: all d and v <= 0 at the edge; in is not captured; inReady is forced to 0 while clear is high.

## Timing
- Reset values: out = 0, outValid = 0, taps = 0, tapValid = 0, count = 0. inReady = 0 while reset is high, then follows adv[0].
- Reset asserted mid-operation clears state asynchronously. No edge is required.
- COLLAPSE=0 latency: an item presented with enable high appears at out exactly DEPTH enabled edges later. Cycles with enable low add no progress.
- COLLAPSE=1 latency:
  - Minimum DEPTH cycles from accept to outValid when enable is held high.
  - Into an empty pipe with enable low, an item reaches stage DEPTH-1 after DEPTH edges and waits there.
- Full (COLLAPSE=1): all v = 1 and enable = 0 gives inReady = 0. Raising enable frees the whole chain in the same cycle, so inReady = 1 and throughput is 1/cycle.
- Simultaneous clear and enable/inValid: clear wins and the pipe is empty next cycle.
- DEPTH = 1: a single stage. adv[0] follows the same rules.
- All outputs except inReady are registered. inReady is a combinational ripple through DEPTH stages.

## Structure
- Shared package/header: COLLAPSE mode constants (MODE_FIXED = 0, MODE_COLLAPSE = 1) and a clog2 helper function.
- Sub-module pipe_stage (parameter n): holds d/v, with inputs load, clear and predecessor data/valid, plus the async reset.
  - delay_pipeline instantiates DEPTH pipe_stage instances in a generate loop.
  - It also computes the adv chain and count.

## Test plan
- Reset:
  - Drive reset high mid-stream with DEPTH=4, n=8 -> outputs go to 0 immediately, before the next edge.
  - Release reset -> count = 0.
- Fixed delay: COLLAPSE=0, DEPTH=4, enable = 1, feed 0x11, 0x22, 0x33 with valid -> out shows 0x11 at edge 4, then 0x22 and 0x33 on consecutive cycles. count peaks at 3 (bubbles not counted).
- Stall: COLLAPSE=0, hold enable low for 3 cycles mid-stream -> taps unchanged during the stall. Data resumes in order with total latency 4 + 3.
- Bubble collapse: COLLAPSE=1, DEPTH=4, enable = 0.
  - Push 0xA1, idle, 0xA2 -> the items pack at stages 3 and 2, then 0xA3/0xA4 fill stages 1 and 0.
  - count = 4 and inReady = 0; a fifth item is not accepted.
  - Set enable = 1 -> out shows 0xA1, 0xA2, 0xA3, 0xA4 on consecutive cycles, and inReady = 1 in the same cycle enable rises.
- Clear priority: with a full pipe, assert clear together with enable = 1 and inValid = 1 for in = 0xFF -> next cycle all tapValid = 0, count = 0, taps = 0. 0xFF never appears.
- DEPTH = 1, COLLAPSE = 1: alternate enable each cycle with inValid held high -> one item out per two cycles. No loss or duplication, checked against a scoreboard.
